ro_trng_sampler: RTL



---
 rtl/ro_trng_pkg.sv | 20 ++
 rtl/ro_bank.sv | 46 ++++
 rtl/ro_trng_sampler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ro_trng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ro_trng_pkg
//  Description : Shared types and constants for the ring-oscillator entropy
//                sampler (debias FSM states, drop counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package ro_trng_pkg;

  // Von Neumann debiaser: waiting for the first bit of a pair, or holding it.
  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    HAVE_FIRST = 1'b1
  } debias_state_e;

  // Width of the saturating dropped-word counter.
  localparam int DROP_W = 8;

endpackage : ro_trng_pkg
`default_nettype wire

// File: rtl/ro_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ro_bank
//  Description : Bank of NUM_RO gated ring oscillators of distinct odd lengths
//                (2*(RO_SIZE+i)+1 stages), XOR-combined into one raw bit.
//                Each stage is a clocked delay element so the ring behaves as
//                an oscillator with a half-period of its stage count in clock
//                cycles; the head stage is the NAND that lets i_en stop it.
//                RO_SIZE must be >= 1 so every ring has at least 3 stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_bank #(
  parameter int NUM_RO  = 4,
  parameter int RO_SIZE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_ro_xor
);

  logic [NUM_RO-1:0] w_ro_out;

  generate
    for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_ro
      localparam int STAGES = 2 * (RO_SIZE + gi) + 1;

      (* keep = "true" *) logic [STAGES-1:0] r_stage;

      // Ring: NAND head (gate + the single net inversion) followed by delay stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stage <= '0;
        end else begin
          r_stage <= {r_stage[STAGES-2:0], ~(i_en & r_stage[STAGES-1])};
        end
      end

      assign w_ro_out[gi] = r_stage[STAGES-1];
    end
  endgenerate

  assign o_ro_xor = ^w_ro_out;

endmodule : ro_bank
`default_nettype wire

// File: rtl/ro_trng_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : ro_trng_sampler
//  Description : Ring-oscillator entropy source. Selected source bit is
//                synchronised, sampled on a programmable divider, checked by a
//                repetition-count health test, optionally von Neumann
//                debiased, packed MSB-first into WORD_W-bit words and offered
//                on a valid/ready handshake. Words completing while the
//                output register is full are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_trng_sampler
  import ro_trng_pkg::*;
#(
  parameter int NUM_RO     = 4,
  parameter int RO_SIZE    = 2,
  parameter int WORD_W     = 32,
  parameter int SAMPLE_DIV = 16,
  parameter int RCT_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_src_sel,
  input  logic              i_debias_en,
  input  logic              i_ext_bit,
  output logic [WORD_W-1:0] o_rnd_data,
  output logic              o_rnd_valid,
  input  logic              i_rnd_ready,
  output logic              o_health_fail,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam int               DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam int               CNT_W     = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_W - 1);
  localparam int               REP_W     = $clog2(RCT_LIMIT + 1);
  localparam logic [REP_W-1:0] REP_LIMIT = REP_W'(RCT_LIMIT);

  logic              w_ro_bit;
  logic              w_src_bit;
  logic              r_sync1;
  logic              r_sync2;
  logic [DIV_W-1:0]  r_div;
  logic              w_tick;
  logic [REP_W-1:0]  r_rep;
  logic [REP_W-1:0]  w_rep_next;
  logic              r_last;
  logic              r_health;
  debias_state_e     r_state;
  logic              r_first;
  logic              r_debias_q;
  logic              w_mode_chg;
  logic              w_emit;
  logic              w_emit_bit;
  logic [WORD_W-2:0] r_shift;
  logic [WORD_W-1:0] w_word;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_word_done;
  logic              w_load;
  logic [WORD_W-1:0] r_data;
  logic              r_valid;
  logic [DROP_W-1:0] r_drop;

  ro_bank #(
    .NUM_RO  (NUM_RO),
    .RO_SIZE (RO_SIZE)
  ) u_ro_bank (
    .clk      (clk),
    .rst      (rst),
    .i_en     (i_en),
    .o_ro_xor (w_ro_bit)
  );

  // Both sources go through the same two flops so their latency matches.
  assign w_src_bit = i_src_sel ? i_ext_bit : w_ro_bit;

  // Two-flop synchroniser, flushed while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else if (!i_en) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_src_bit;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = i_en && (r_div == DIV_LAST);

  // Sample divider: counts 0..SAMPLE_DIV-1, tick on the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (!i_en || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Run length restarts at 1 on the first sample or on a change; saturates at the limit.
  assign w_rep_next = ((r_rep == '0) || (r_sync2 != r_last)) ? REP_W'(1) :
                      (r_rep == REP_LIMIT)                   ? REP_LIMIT :
                                                               r_rep + REP_W'(1);

  // Repetition-count health test; failure is sticky until reset or disable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep    <= '0;
      r_last   <= 1'b0;
      r_health <= 1'b0;
    end else if (!i_en) begin
      r_rep    <= '0;
      r_last   <= 1'b0;
      r_health <= 1'b0;
    end else if (w_tick) begin
      r_rep  <= w_rep_next;
      r_last <= r_sync2;
      if (w_rep_next == REP_LIMIT) begin
        r_health <= 1'b1;
      end
    end
  end

  // A mode switch abandons any half-collected pair.
  assign w_mode_chg = (i_debias_en != r_debias_q);

  // Raw mode emits every sample; debias mode emits the first bit of an unequal pair.
  assign w_emit = i_debias_en ? (w_tick && !w_mode_chg && (r_state == HAVE_FIRST) &&
                                 (r_first != r_sync2))
                              : w_tick;
  assign w_emit_bit = i_debias_en ? r_first : r_sync2;

  // Von Neumann pairing FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_first    <= 1'b0;
      r_debias_q <= 1'b0;
    end else begin
      r_debias_q <= i_debias_en;
      if (!i_en || w_mode_chg || !i_debias_en) begin
        r_state <= IDLE;
      end else if (w_tick) begin
        case (r_state)
          IDLE: begin
            r_first <= r_sync2;
            r_state <= HAVE_FIRST;
          end
          HAVE_FIRST: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // The first emitted bit of a word shifts all the way up to the MSB.
  assign w_word      = {r_shift, w_emit_bit};
  assign w_word_done = w_emit && (r_cnt == CNT_LAST);
  assign w_load      = w_word_done && (!r_valid || i_rnd_ready);

  // Shift register and bit counter; the count restarts whether or not the word is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else if (w_emit) begin
      r_shift <= w_word[WORD_W-2:0];
      r_cnt   <= w_word_done ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Output register: hold until accepted; a same-cycle accept and load keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (r_valid && i_rnd_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating count of words lost to a full output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_word_done && !w_load && (r_drop != {DROP_W{1'b1}})) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign o_rnd_data    = r_data;
  assign o_rnd_valid   = r_valid;
  assign o_health_fail = r_health;
  assign o_drop_cnt    = r_drop;

endmodule : ro_trng_sampler
`default_nettype wire
